// File: rtl/target_generator.sv
// Snake-game target placer: two free-running LFSRs propose grid positions,
// an FSM latches in-range candidates and scores edge-detected target hits.
module target_generator #(
  parameter logic [7:0]  SEED_X = 8'hA5,
  parameter logic [6:0]  SEED_Y = 7'h3C,
  parameter int unsigned MAX_X  = 160,
  parameter int unsigned MAX_Y  = 120
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] MSM_STATE,
  input  logic       TARGET_REACHED,
  output logic [7:0] TARGET_ADDR_X,
  output logic [6:0] TARGET_ADDR_Y,
  output logic       TARGET_VALID,
  output logic       NEW_TARGET,
  output logic [7:0] SCORE
);

  typedef enum logic [1:0] {IDLE, SEARCH, HOLD, FREEZE} state_t;

  state_t     r_state, w_state_nxt;
  state_t     r_from, w_from_nxt;
  logic [7:0] r_lfsr_x, w_lfsr_x_nxt;
  logic [6:0] r_lfsr_y, w_lfsr_y_nxt;
  logic       r_reached_d;
  logic [7:0] r_addr_x, w_addr_x_nxt;
  logic [6:0] r_addr_y, w_addr_y_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_new, w_new_nxt;
  logic [7:0] r_score, w_score_nxt;
  logic       w_accept;
  logic       w_event;

  // Fibonacci shift-left: x^8+x^6+x^5+x^4+1 and x^7+x^6+1
  assign w_lfsr_x_nxt = {r_lfsr_x[6:0], r_lfsr_x[7] ^ r_lfsr_x[5] ^ r_lfsr_x[4] ^ r_lfsr_x[3]};
  assign w_lfsr_y_nxt = {r_lfsr_y[5:0], r_lfsr_y[6] ^ r_lfsr_y[5]};

  assign w_accept = ({1'b0, r_lfsr_x} < 9'(MAX_X)) &&
                    ({1'b0, r_lfsr_y} < 8'(MAX_Y)) &&
                    ({r_lfsr_x, r_lfsr_y} != {r_addr_x, r_addr_y});
  assign w_event  = TARGET_REACHED & ~r_reached_d;

  always_comb begin
    w_state_nxt  = r_state;
    w_from_nxt   = r_from;
    w_addr_x_nxt = r_addr_x;
    w_addr_y_nxt = r_addr_y;
    w_valid_nxt  = r_valid;
    w_score_nxt  = r_score;
    w_new_nxt    = 1'b0;
    // MSM going idle overrides everything, including a same-cycle hit
    if (MSM_STATE == 2'd0) begin
      w_state_nxt = IDLE;
      w_score_nxt = '0;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (MSM_STATE == 2'd1) w_state_nxt = SEARCH;
        end
        SEARCH: begin
          if (MSM_STATE != 2'd1) begin
            w_from_nxt  = SEARCH;
            w_state_nxt = FREEZE;
          end else if (w_accept) begin
            w_addr_x_nxt = r_lfsr_x;
            w_addr_y_nxt = r_lfsr_y;
            w_valid_nxt  = 1'b1;
            w_new_nxt    = 1'b1;
            w_state_nxt  = HOLD;
          end
        end
        HOLD: begin
          if (MSM_STATE != 2'd1) begin
            w_from_nxt  = HOLD;
            w_state_nxt = FREEZE;
          end else if (w_event) begin
            w_score_nxt = (r_score != 8'hFF) ? r_score + 8'd1 : r_score;
            w_valid_nxt = 1'b0;
            w_state_nxt = SEARCH;
          end
        end
        FREEZE: begin
          if (MSM_STATE == 2'd1) w_state_nxt = r_from;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= IDLE;
      r_from      <= SEARCH;
      r_lfsr_x    <= SEED_X;
      r_lfsr_y    <= SEED_Y;
      r_reached_d <= 1'b0;
      r_addr_x    <= 8'd40;
      r_addr_y    <= 7'd30;
      r_valid     <= 1'b0;
      r_new       <= 1'b0;
      r_score     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_from      <= w_from_nxt;
      r_lfsr_x    <= w_lfsr_x_nxt;
      r_lfsr_y    <= w_lfsr_y_nxt;
      r_reached_d <= TARGET_REACHED;
      r_addr_x    <= w_addr_x_nxt;
      r_addr_y    <= w_addr_y_nxt;
      r_valid     <= w_valid_nxt;
      r_new       <= w_new_nxt;
      r_score     <= w_score_nxt;
    end
  end

  assign TARGET_ADDR_X = r_addr_x;
  assign TARGET_ADDR_Y = r_addr_y;
  assign TARGET_VALID  = r_valid;
  assign NEW_TARGET    = r_new;
  assign SCORE         = r_score;

endmodule

// File: tb/tb_target_generator.sv
// Randomized scoreboard bench for target_generator against a rule-level reference model.
module tb_target_generator;

  localparam int unsigned POLY_X = (1 << 8) | (1 << 6) | (1 << 5) | (1 << 4);
  localparam int unsigned POLY_Y = (1 << 7) | (1 << 6);
  localparam int M_IDLE = 0, M_SEARCH = 1, M_HOLD = 2, M_FREEZE = 3;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] MSM_STATE = 2'd0;
  logic       TARGET_REACHED = 1'b0;
  logic [7:0] TARGET_ADDR_X;
  logic [6:0] TARGET_ADDR_Y;
  logic       TARGET_VALID;
  logic       NEW_TARGET;
  logic [7:0] SCORE;

  target_generator #(
    .SEED_X(8'hA5),
    .SEED_Y(7'h3C),
    .MAX_X (160),
    .MAX_Y (120)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .MSM_STATE     (MSM_STATE),
    .TARGET_REACHED(TARGET_REACHED),
    .TARGET_ADDR_X (TARGET_ADDR_X),
    .TARGET_ADDR_Y (TARGET_ADDR_Y),
    .TARGET_VALID  (TARGET_VALID),
    .NEW_TARGET    (NEW_TARGET),
    .SCORE         (SCORE)
  );

  always #5 CLK = ~CLK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned nt_count = 0;

  typedef struct {
    int unsigned x;
    int unsigned y;
    int unsigned score;
  } tgt_t;
  tgt_t exp_q[$];

  // Reference model state
  int unsigned m_lx = 8'hA5, m_ly = 7'h3C;
  int unsigned m_x = 40, m_y = 30, m_score = 0;
  int          m_mode = M_IDLE, m_from = M_SEARCH;
  bit          m_valid = 0, m_rd = 0;

  function automatic void chk(string name, longint got, longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // Next Fibonacci LFSR value from polynomial exponents (shift toward MSB)
  function automatic int unsigned fib_step(int unsigned v, int unsigned n, int unsigned poly);
    int unsigned fb = 0;
    for (int unsigned k = 1; k <= n; k++)
      if (poly[k]) fb ^= (v >> (k - 1)) & 1;
    return ((v << 1) | fb) & ((1 << n) - 1);
  endfunction

  function automatic void model_reset();
    m_lx = 8'hA5; m_ly = 7'h3C;
    m_x = 40; m_y = 30; m_score = 0;
    m_mode = M_IDLE; m_from = M_SEARCH;
    m_valid = 0; m_rd = 0;
    exp_q.delete();
  endfunction

  function automatic void model_step();
    bit hit;
    hit = TARGET_REACHED && !m_rd;
    if (MSM_STATE == 0) begin
      m_mode = M_IDLE; m_score = 0; m_valid = 0;
    end else if (m_mode == M_IDLE) begin
      if (MSM_STATE == 1) m_mode = M_SEARCH;
    end else if (m_mode == M_FREEZE) begin
      if (MSM_STATE == 1) m_mode = m_from;
    end else if (MSM_STATE != 1) begin
      m_from = m_mode; m_mode = M_FREEZE;
    end else if (m_mode == M_SEARCH) begin
      if (m_lx < 160 && m_ly < 120 && !(m_lx == m_x && m_ly == m_y)) begin
        m_x = m_lx; m_y = m_ly; m_valid = 1; m_mode = M_HOLD;
        exp_q.push_back('{m_x, m_y, m_score});
      end
    end else if (hit) begin
      if (m_score < 255) m_score++;
      m_valid = 0; m_mode = M_SEARCH;
    end
    m_rd = TARGET_REACHED;
    m_lx = fib_step(m_lx, 8, POLY_X);
    m_ly = fib_step(m_ly, 7, POLY_Y);
  endfunction

  initial forever begin
    @(posedge CLK or negedge RESET);
    if (!RESET) model_reset();
    else model_step();
  end

  // Monitor: compares every cycle and pops the scoreboard on each NEW_TARGET
  int unsigned last_x = 40, last_y = 30;
  bit          prev_nt = 0;
  initial forever begin
    @(negedge CLK);
    if (!RESET) begin
      last_x = 40; last_y = 30; prev_nt = 0;
    end else begin
      n_tests++;
      if (SCORE != m_score || TARGET_VALID != m_valid ||
          TARGET_ADDR_X != m_x || TARGET_ADDR_Y != m_y) begin
        n_fail++;
        $display("FAIL state: got score=%0d valid=%0d x=%0d y=%0d expected score=%0d valid=%0d x=%0d y=%0d",
                 SCORE, TARGET_VALID, TARGET_ADDR_X, TARGET_ADDR_Y, m_score, m_valid, m_x, m_y);
      end
      if (NEW_TARGET || exp_q.size() != 0) begin
        if (!NEW_TARGET) begin
          chk("missed_new_target", 0, 1);
          void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          chk("spurious_new_target", 1, 0);
        end else begin
          tgt_t t;
          t = exp_q.pop_front();
          chk("tgt_x", TARGET_ADDR_X, t.x);
          chk("tgt_y", TARGET_ADDR_Y, t.y);
          chk("tgt_score", SCORE, t.score);
          chk("tgt_range", (TARGET_ADDR_X < 160 && TARGET_ADDR_Y < 120), 1);
          chk("tgt_differs", (TARGET_ADDR_X != last_x || TARGET_ADDR_Y != last_y), 1);
          chk("tgt_valid", TARGET_VALID, 1);
        end
      end
      if (NEW_TARGET) begin
        chk("nt_not_consecutive", prev_nt, 0);
        nt_count++;
        last_x = TARGET_ADDR_X; last_y = TARGET_ADDR_Y;
      end
      prev_nt = NEW_TARGET;
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 33000; i++) begin
      @(negedge CLK);
      if (TARGET_VALID === 1'b1) return;
    end
    chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_x"}, TARGET_ADDR_X, 40);
    chk({tag, "_y"}, TARGET_ADDR_Y, 30);
    chk({tag, "_valid"}, TARGET_VALID, 0);
    chk({tag, "_new"}, NEW_TARGET, 0);
    chk({tag, "_score"}, SCORE, 0);
    chk({tag, "_lfsr_x"}, dut.r_lfsr_x, 8'hA5);
    chk({tag, "_lfsr_y"}, dut.r_lfsr_y, 7'h3C);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nt0, sc, ax, ay;

    // Async reset, visible before the first clock edge
    #2 RESET = 1'b0;
    #1 check_reset_values("rst_async");
    cycles(3);
    check_reset_values("rst_held");
    RESET = 1'b1;
    MSM_STATE = 2'd1;

    // First placement
    nt0 = nt_count;
    wait_valid();
    chk("place_pulses", nt_count - nt0, 1);
    chk("place_not_reset_addr", (TARGET_ADDR_X != 40 || TARGET_ADDR_Y != 30), 1);

    // Held level counts once
    TARGET_REACHED = 1'b1;
    nt0 = nt_count;
    cycles(1000);
    TARGET_REACHED = 1'b0;
    chk("edge_score", SCORE, 1);
    chk("edge_pulses", nt_count - nt0, 1);

    // Saturation with randomized hit timing and width
    repeat (260) begin
      wait_valid();
      cycles($urandom_range(0, 3));
      TARGET_REACHED = 1'b1;
      cycles($urandom_range(1, 4));
      TARGET_REACHED = 1'b0;
    end
    wait_valid();
    chk("sat_score", SCORE, 255);

    // Freeze from HOLD with a simultaneous hit edge
    sc = SCORE; ax = TARGET_ADDR_X; ay = TARGET_ADDR_Y;
    MSM_STATE = 2'd2;
    TARGET_REACHED = 1'b1;
    cycles(5);
    TARGET_REACHED = 1'b0;
    chk("freeze_score", SCORE, sc);
    chk("freeze_valid", TARGET_VALID, 1);
    chk("freeze_addr", {TARGET_ADDR_X, 1'b0, TARGET_ADDR_Y}, {ax[7:0], 1'b0, ay[6:0]});
    MSM_STATE = 2'd1;
    cycles(3);
    chk("unfreeze_valid", TARGET_VALID, 1);
    chk("unfreeze_score", SCORE, sc);
    MSM_STATE = 2'd0;
    cycles(2);
    chk("idle_score", SCORE, 0);
    chk("idle_valid", TARGET_VALID, 0);

    // Freeze from SEARCH, then resume searching
    MSM_STATE = 2'd1;
    cycles(1);
    MSM_STATE = 2'd3;
    nt0 = nt_count;
    cycles(6);
    chk("freeze_search_pulses", nt_count - nt0, 0);
    chk("freeze_search_valid", TARGET_VALID, 0);
    MSM_STATE = 2'd1;
    wait_valid();

    // Random MSM / hit traffic, checked cycle by cycle by the monitor
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 19) == 0)
        MSM_STATE = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'($urandom_range(0, 3));
      TARGET_REACHED = ($urandom_range(0, 3) == 0);
    end
    TARGET_REACHED = 1'b0;

    // Async reset mid-SEARCH
    MSM_STATE = 2'd0;
    cycles(2);
    MSM_STATE = 2'd1;
    @(posedge CLK);
    #3 RESET = 1'b0;
    #1 check_reset_values("rst_search");
    @(negedge CLK);
    RESET = 1'b1;
    wait_valid();
    cycles(2);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
